// File: rtl/axi4_ram_responder_if.sv
// AXI4 bus bundle between the bridge master port and the RAM responder.
// master drives requests; slave returns ready/response signals.
interface axi4_ram_responder_if #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 31,
  parameter int DATA_WIDTH = 64
);
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arvalid;
  logic                    arready;
  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    input  wdata, wstrb, wlast, wvalid, bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    input  rready,
    output awready, wready, bid, bresp, bvalid,
    output arready, rid, rdata, rresp, rlast, rvalid
  );

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    output wdata, wstrb, wlast, wvalid, bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    output rready,
    input  awready, wready, bid, bresp, bvalid,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi4_ram_responder.sv
// AXI4 subordinate backed by on-chip RAM; one burst in flight at a time.
// Define AXI_RAM_WRAP_EN to support WRAP bursts (len 1/3/7/15).
module axi4_ram_responder #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 31,
  parameter int DATA_WIDTH = 64,
  parameter int MEM_BYTES  = 65536
) (
  input logic                 s_axi_aclk,
  input logic                 s_axi_aresetn,
  axi4_ram_responder_if.slave s_axi
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int LB    = $clog2(NB);
  localparam int MAW   = $clog2(MEM_BYTES);
  localparam int IXW   = MAW - LB;
  localparam int DEPTH = MEM_BYTES / NB;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    WDATA,
    WRESP,
    RADDR,
    RDATA
  } state_e;

  state_e state_q, state_d;

  logic                  en_q;
  logic                  last_rd_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [2:0]            size_q;
  logic [1:0]            burst_q;
  logic                  berr_q;
  logic                  werr_q, werr_d;
  logic                  iss_done_q;

`ifdef AXI_RAM_WRAP_EN
  logic                  wrap_q;
  logic [ADDR_WIDTH-1:0] wmask_q;
  logic                  cap_wrap;
  logic [ADDR_WIDTH-1:0] cap_wmask;

  function automatic logic wrap_ok(input logic [7:0] l);
    return (l == 8'd1) || (l == 8'd3) ||
           (l == 8'd7) || (l == 8'd15);
  endfunction
`endif

  logic                  aw_hs, ar_hs;
  logic                  wr_hs, r_hs;
  logic                  out_ld, issue, oor;
  logic [IXW-1:0]        idx;

  logic [ID_WIDTH-1:0]   cap_id;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic [7:0]            cap_len;
  logic [2:0]            cap_size;
  logic [2:0]            cap_sz;
  logic [1:0]            cap_burst;
  logic                  cap_berr;

  logic [ADDR_WIDTH-1:0] nb, al, nxt;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] p_data_q;
  logic                  p_vld_q, p_err_q;
  logic                  p_oor_q, p_last_q;

  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;
  logic                  rlast_q;

  // Round-robin: write wins a tie only after a read grant.
  assign s_axi.awready = en_q && (state_q == IDLE) &&
                         s_axi.awvalid &&
                         (!s_axi.arvalid || last_rd_q);
  assign s_axi.arready = en_q && (state_q == IDLE) &&
                         s_axi.arvalid &&
                         (!s_axi.awvalid || !last_rd_q);

  assign aw_hs = s_axi.awvalid && s_axi.awready;
  assign ar_hs = s_axi.arvalid && s_axi.arready;

  assign s_axi.wready = (state_q == WDATA);
  assign wr_hs        = (state_q == WDATA) && s_axi.wvalid;

  assign s_axi.bvalid = (state_q == WRESP);
  assign s_axi.bid    = id_q;
  assign s_axi.bresp  = werr_q ? SLVERR : OKAY;

  assign s_axi.rvalid = rvalid_q;
  assign s_axi.rid    = id_q;
  assign s_axi.rdata  = rdata_q;
  assign s_axi.rresp  = rresp_q;
  assign s_axi.rlast  = rlast_q;

  assign r_hs   = rvalid_q && s_axi.rready;
  assign out_ld = p_vld_q && (!rvalid_q || s_axi.rready);
  // Prefetch the next beat whenever the staging slot frees up.
  assign issue  = ((state_q == RADDR) || (state_q == RDATA)) &&
                  !iss_done_q && (!p_vld_q || out_ld);

  assign oor = |addr_q[ADDR_WIDTH-1:MAW];
  assign idx = addr_q[MAW-1:LB];

  always_comb begin
    cap_id    = aw_hs ? s_axi.awid    : s_axi.arid;
    cap_addr  = aw_hs ? s_axi.awaddr  : s_axi.araddr;
    cap_len   = aw_hs ? s_axi.awlen   : s_axi.arlen;
    cap_size  = aw_hs ? s_axi.awsize  : s_axi.arsize;
    cap_burst = aw_hs ? s_axi.awburst : s_axi.arburst;
    cap_sz    = (cap_size > 3'(LB)) ? 3'(LB) : cap_size;
    cap_berr  = (cap_burst == 2'b11) || (cap_size > 3'(LB));
`ifdef AXI_RAM_WRAP_EN
    cap_wrap  = (cap_burst == 2'b10) && wrap_ok(cap_len);
    cap_wmask = ((ADDR_WIDTH'(cap_len) + ADDR_WIDTH'(1))
                 << cap_sz) - ADDR_WIDTH'(1);
    if ((cap_burst == 2'b10) && !cap_wrap)
      cap_berr = 1'b1;
`else
    if (cap_burst == 2'b10)
      cap_berr = 1'b1;
`endif
  end

  always_comb begin
    nb  = ADDR_WIDTH'(1) << size_q;
    al  = addr_q & ~(nb - ADDR_WIDTH'(1));
    nxt = al + nb;
    if (burst_q == 2'b00)
      nxt = addr_q;
`ifdef AXI_RAM_WRAP_EN
    else if (wrap_q)
      nxt = (al & ~wmask_q) | (nxt & wmask_q);
`endif
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    werr_d  = werr_q;
    if (aw_hs || ar_hs) begin
      addr_d = cap_addr;
      cnt_d  = cap_len;
      werr_d = cap_berr;
    end else if (wr_hs || issue) begin
      addr_d = nxt;
      if (cnt_q != 8'd0)
        cnt_d = cnt_q - 8'd1;
    end
    // The beat counter ends the burst; a wrong wlast only flags an error.
    if (wr_hs && (oor || (s_axi.wlast != (cnt_q == 8'd0))))
      werr_d = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (aw_hs)
          state_d = WDATA;
        else if (ar_hs)
          state_d = RADDR;
      end
      WDATA: begin
        if (wr_hs && (cnt_q == 8'd0))
          state_d = WRESP;
      end
      WRESP: begin
        if (s_axi.bready)
          state_d = IDLE;
      end
      RADDR: state_d = RDATA;
      RDATA: begin
        if (r_hs && rlast_q)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q    <= IDLE;
      en_q       <= 1'b0;
      last_rd_q  <= 1'b1;
      id_q       <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      size_q     <= '0;
      burst_q    <= '0;
      berr_q     <= 1'b0;
      werr_q     <= 1'b0;
      iss_done_q <= 1'b0;
      p_vld_q    <= 1'b0;
      p_err_q    <= 1'b0;
      p_oor_q    <= 1'b0;
      p_last_q   <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= OKAY;
      rlast_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= 1'b1;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      werr_q  <= werr_d;
      if (aw_hs || ar_hs) begin
        id_q       <= cap_id;
        size_q     <= cap_sz;
        burst_q    <= cap_burst;
        berr_q     <= cap_berr;
        iss_done_q <= 1'b0;
      end
      if (aw_hs)
        last_rd_q <= 1'b0;
      else if (ar_hs)
        last_rd_q <= 1'b1;
      if (issue) begin
        p_vld_q  <= 1'b1;
        p_err_q  <= oor || berr_q;
        p_oor_q  <= oor;
        p_last_q <= (cnt_q == 8'd0);
        if (cnt_q == 8'd0)
          iss_done_q <= 1'b1;
      end else if (out_ld) begin
        p_vld_q <= 1'b0;
      end
      if (out_ld) begin
        rvalid_q <= 1'b1;
        rdata_q  <= p_oor_q ? '0 : p_data_q;
        rresp_q  <= p_err_q ? SLVERR : OKAY;
        rlast_q  <= p_last_q;
      end else if (r_hs) begin
        rvalid_q <= 1'b0;
      end
    end
  end

`ifdef AXI_RAM_WRAP_EN
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      wrap_q  <= 1'b0;
      wmask_q <= '0;
    end else if (aw_hs || ar_hs) begin
      wrap_q  <= cap_wrap;
      wmask_q <= cap_wmask;
    end
  end
`endif

  // RAM contents survive reset; partial bursts stay written.
  always_ff @(posedge s_axi_aclk) begin
    if (wr_hs && !oor) begin
      for (int i = 0; i < NB; i++) begin
        if (s_axi.wstrb[i])
          mem[idx][i*8 +: 8] <= s_axi.wdata[i*8 +: 8];
      end
    end
    if (issue)
      p_data_q <= mem[idx];
  end

endmodule

// File: tb/tb_axi4_ram_responder.sv
// Scoreboard bench for axi4_ram_responder: directed bursts, queued
// expectations, and a negedge monitor that checks every R/B handshake.
module tb_axi4_ram_responder;
  localparam int IW = 4;
  localparam int AW = 31;
  localparam int DW = 64;
  localparam int MB = 65536;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi4_ram_responder_if #(
    .ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
  ) bus ();

  axi4_ram_responder #(
    .ID_WIDTH(IW), .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW), .MEM_BYTES(MB)
  ) dut (
    .s_axi_aclk(clk),
    .s_axi_aresetn(rst_n),
    .s_axi(bus.slave)
  );

  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    logic [1:0]    resp;
    logic          last;
  } r_exp_t;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [1:0]    resp;
  } b_exp_t;

  r_exp_t rq[$];
  b_exp_t bq[$];
  r_exp_t re;
  b_exp_t be;
  int total = 0;
  int bad = 0;
  logic [63:0] wd[16];
  logic [7:0]  ws[16];
  logic        hold_v = 1'b0;
  logic [IW+DW+2:0] hold;
  logic [3:0]  pat = 4'b1001;
  int          lat;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    total++;
    bad++;
    $display("FAIL %s: got timeout want handshake", nm);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("ready_excl", 128'(bus.awready & bus.arready), 0);
      if (bus.rvalid) begin
        if (hold_v)
          chk("r_stable", {bus.rid, bus.rdata, bus.rresp, bus.rlast}, hold);
        if (bus.rready) begin
          hold_v = 1'b0;
          if (rq.size() == 0) begin
            tmo("r_extra_beat");
          end else begin
            re = rq.pop_front();
            chk("r_id", bus.rid, re.id);
            chk("r_data", bus.rdata, re.data);
            chk("r_resp", bus.rresp, re.resp);
            chk("r_last", bus.rlast, re.last);
          end
        end else begin
          hold_v = 1'b1;
          hold = {bus.rid, bus.rdata, bus.rresp, bus.rlast};
        end
      end
      if (bus.bvalid && bus.bready) begin
        if (bq.size() == 0) begin
          tmo("b_extra");
        end else begin
          be = bq.pop_front();
          chk("b_id", bus.bid, be.id);
          chk("b_resp", bus.bresp, be.resp);
        end
      end
    end
  end

  task automatic send_aw(input logic [3:0] id, input logic [30:0] a,
                         input logic [7:0] l, input logic [2:0] s,
                         input logic [1:0] b);
    int n;
    bus.awid = id; bus.awaddr = a; bus.awlen = l;
    bus.awsize = s; bus.awburst = b; bus.awvalid = 1'b1;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus.awready) break;
    end
    if (n == 200) tmo("aw_wait");
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
  endtask

  task automatic send_w(input int l, input int lastidx);
    int n;
    for (int k = 0; k <= l; k++) begin
      bus.wdata = wd[k]; bus.wstrb = ws[k];
      bus.wlast = (k == lastidx); bus.wvalid = 1'b1;
      for (n = 0; n < 200; n++) begin
        @(negedge clk);
        if (bus.wready) break;
      end
      if (n == 200) tmo("w_wait");
      @(posedge clk); #1;
    end
    bus.wvalid = 1'b0;
    bus.wlast = 1'b0;
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [30:0] a,
                         input logic [7:0] l, input logic [2:0] s,
                         input logic [1:0] b, output int lt);
    int n;
    bus.arid = id; bus.araddr = a; bus.arlen = l;
    bus.arsize = s; bus.arburst = b; bus.arvalid = 1'b1;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus.arready) break;
    end
    if (n == 200) tmo("ar_wait");
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    lt = 0;
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bus.rvalid) break;
      @(posedge clk);
      lt++;
    end
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (rq.size() == 0 && bq.size() == 0) break;
    end
    if (i == 400) tmo("drain");
  endtask

  task automatic wr1(input logic [3:0] id, input logic [30:0] a,
                     input logic [63:0] d);
    bq.push_back('{id, 2'b00});
    wd[0] = d; ws[0] = 8'hFF;
    send_aw(id, a, 8'd0, 3'd3, 2'b01);
    send_w(0, 0);
    drain();
  endtask

  // Tie between AW and AR: check which channel is granted first.
  task automatic arb(input logic exp_rd, input logic [30:0] wa,
                     input logic [30:0] ra);
    int n;
    ws[0] = 8'hFF;
    bus.awid = 4'd8; bus.awaddr = wa; bus.awlen = 8'd0;
    bus.awsize = 3'd3; bus.awburst = 2'b01;
    bus.arid = 4'd9; bus.araddr = ra; bus.arlen = 8'd0;
    bus.arsize = 3'd3; bus.arburst = 2'b01;
    bus.awvalid = 1'b1; bus.arvalid = 1'b1;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus.awready || bus.arready) break;
    end
    if (n == 200) tmo("arb_wait");
    chk("arb_grant_rd", bus.arready, exp_rd);
    if (bus.arready) begin
      @(posedge clk); #1;
      bus.arvalid = 1'b0;
      send_aw(4'd8, wa, 8'd0, 3'd3, 2'b01);
      send_w(0, 0);
    end else begin
      @(posedge clk); #1;
      bus.awvalid = 1'b0;
      send_w(0, 0);
      send_ar(4'd9, ra, 8'd0, 3'd3, 2'b01, lat);
    end
    drain();
  endtask

  initial begin
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0;
    bus.awsize = '0; bus.awburst = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0;
    bus.wvalid = 1'b0; bus.bready = 1'b1;
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0;
    bus.arsize = '0; bus.arburst = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", bus.awready, 0);
    chk("rst_arready", bus.arready, 0);
    chk("rst_wready", bus.wready, 0);
    chk("rst_bvalid", bus.bvalid, 0);
    chk("rst_rvalid", bus.rvalid, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_rlast", bus.rlast, 0);
    chk("rst_resp_ids", {bus.bid, bus.rid, bus.bresp, bus.rresp}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single write then read back, with first-beat latency.
    wr1(4'd1, 31'h100, 64'h1122334455667788);
    rq.push_back('{4'd2, 64'h1122334455667788, 2'b00, 1'b1});
    send_ar(4'd2, 31'h100, 8'd0, 3'd3, 2'b01, lat);
    chk("r_latency", lat, 2);
    drain();

    // Oversized beat clamps to full width and flags SLVERR.
    rq.push_back('{4'd2, 64'h1122334455667788, 2'b10, 1'b1});
    send_ar(4'd2, 31'h100, 8'd0, 3'd4, 2'b01, lat);
    drain();

    // INCR len 3 with a partial strobe on beat 2.
    wr1(4'd3, 31'h210, 64'hDEADBEEFCAFEF00D);
    bq.push_back('{4'd4, 2'b00});
    wd[0] = 64'h1111111111111111; ws[0] = 8'hFF;
    wd[1] = 64'h2222222222222222; ws[1] = 8'hFF;
    wd[2] = 64'h3333333333333333; ws[2] = 8'h0F;
    wd[3] = 64'h4444444444444444; ws[3] = 8'hFF;
    send_aw(4'd4, 31'h200, 8'd3, 3'd3, 2'b01);
    send_w(3, 3);
    drain();
    rq.push_back('{4'd5, 64'h1111111111111111, 2'b00, 1'b0});
    rq.push_back('{4'd5, 64'h2222222222222222, 2'b00, 1'b0});
    rq.push_back('{4'd5, 64'hDEADBEEF33333333, 2'b00, 1'b0});
    rq.push_back('{4'd5, 64'h4444444444444444, 2'b00, 1'b1});
    send_ar(4'd5, 31'h200, 8'd3, 3'd3, 2'b01, lat);
    drain();

    // 8-beat read under rready back-pressure 1,0,0,1.
    bq.push_back('{4'd6, 2'b00});
    for (int k = 0; k < 8; k++) begin
      wd[k] = 64'hC0DE000000000000 | 64'(k);
      ws[k] = 8'hFF;
    end
    send_aw(4'd6, 31'h400, 8'd7, 3'd3, 2'b01);
    send_w(7, 7);
    drain();
    for (int k = 0; k < 8; k++)
      rq.push_back('{4'd7, 64'hC0DE000000000000 | 64'(k),
                     2'b00, (k == 7)});
    fork
      send_ar(4'd7, 31'h400, 8'd7, 3'd3, 2'b01, lat);
      begin
        for (int i = 0; i < 40; i++) begin
          bus.rready = pat[i % 4];
          @(posedge clk); #1;
        end
        bus.rready = 1'b1;
      end
    join
    drain();

    // Tie after a read grant: write first, then the pending read.
    wd[0] = 64'h0123456789ABCDEF;
    bq.push_back('{4'd8, 2'b00});
    rq.push_back('{4'd9, 64'hC0DE000000000000, 2'b00, 1'b1});
    arb(1'b0, 31'h500, 31'h400);

    // wlast on the wrong beat: counter ends burst, B is SLVERR.
    bq.push_back('{4'd10, 2'b10});
    wd[0] = 64'h0; ws[0] = 8'hFF;
    wd[1] = 64'h0; ws[1] = 8'hFF;
    send_aw(4'd10, 31'h600, 8'd1, 3'd3, 2'b01);
    send_w(1, 0);
    drain();

    // Tie after a write grant: read first.
    wd[0] = 64'hAAAA5555AAAA5555;
    bq.push_back('{4'd8, 2'b00});
    rq.push_back('{4'd9, 64'h0123456789ABCDEF, 2'b00, 1'b1});
    arb(1'b1, 31'h508, 31'h500);

    // Burst crossing the top of RAM.
    wr1(4'd1, 31'hFFF8, 64'h5A5A5A5A5A5A5A5A);
    rq.push_back('{4'd2, 64'h5A5A5A5A5A5A5A5A, 2'b00, 1'b0});
    rq.push_back('{4'd2, 64'h0, 2'b10, 1'b1});
    send_ar(4'd2, 31'hFFF8, 8'd1, 3'd3, 2'b01, lat);
    drain();

    // WRAP len 3 at 0x318.
    bq.push_back('{4'd3, 2'b00});
    for (int k = 0; k < 8; k++) begin
      wd[k] = {32'hB0B0B0B0, 32'h300 + 32'(8 * k)};
      ws[k] = 8'hFF;
    end
    send_aw(4'd3, 31'h300, 8'd7, 3'd3, 2'b01);
    send_w(7, 7);
    drain();
`ifdef AXI_RAM_WRAP_EN
    rq.push_back('{4'd4, 64'hB0B0B0B000000318, 2'b00, 1'b0});
    rq.push_back('{4'd4, 64'hB0B0B0B000000300, 2'b00, 1'b0});
    rq.push_back('{4'd4, 64'hB0B0B0B000000308, 2'b00, 1'b0});
    rq.push_back('{4'd4, 64'hB0B0B0B000000310, 2'b00, 1'b1});
`else
    rq.push_back('{4'd4, 64'hB0B0B0B000000318, 2'b10, 1'b0});
    rq.push_back('{4'd4, 64'hB0B0B0B000000320, 2'b10, 1'b0});
    rq.push_back('{4'd4, 64'hB0B0B0B000000328, 2'b10, 1'b0});
    rq.push_back('{4'd4, 64'hB0B0B0B000000330, 2'b10, 1'b1});
`endif
    send_ar(4'd4, 31'h318, 8'd3, 3'd3, 2'b10, lat);
    drain();

    chk("r_queue_empty", 128'(rq.size()), 0);
    chk("b_queue_empty", 128'(bq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
